// File: rtl/dmem_arbiter.sv
// Round-robin arbiter/sequencer that lets the core (port 0) and a DMA/debug master (port 1)
// share one data memory, with a single transaction in flight (IDLE -> ACCESS -> RESP).
module dmem_arbiter #(
  parameter int DM_ADDRESS = 9,
  parameter int DATA_W     = 32
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [1:0]              req_valid,
  input  logic [1:0]              req_write,
  input  logic [2*DM_ADDRESS-1:0] req_addr,
  input  logic [2*DATA_W-1:0]     req_wdata,
  input  logic [5:0]              req_funct3,
  output logic [1:0]              req_ready,
  output logic [1:0]              rsp_valid,
  output logic [DATA_W-1:0]       rsp_rdata,
  output logic                    busy,
  output logic                    MemRead,
  output logic                    MemWrite,
  output logic [DM_ADDRESS-1:0]   a,
  output logic [DATA_W-1:0]       wd,
  output logic [2:0]              Funct3,
  input  logic [DATA_W-1:0]       rd
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RESP   = 2'd2
  } state_t;

  state_t                r_state;
  logic                  r_rrLast;
  logic                  r_gnt;
  logic                  r_write;
  logic [DM_ADDRESS-1:0] r_addr;
  logic [DATA_W-1:0]     r_wdata;
  logic [2:0]            r_funct3;
  logic [DATA_W-1:0]     r_rdata;

  logic                  w_gnt;
  logic                  w_write;
  logic [DM_ADDRESS-1:0] w_addr;
  logic [DATA_W-1:0]     w_wdata;
  logic [2:0]            w_funct3;

  // On a conflict the port that was not served last wins.
  always_comb begin
    w_gnt = 1'b0;
    if (req_valid == 2'b10) begin
      w_gnt = 1'b1;
    end else if (req_valid == 2'b11) begin
      w_gnt = ~r_rrLast;
    end
  end

  assign w_write  = w_gnt ? req_write[1] : req_write[0];
  assign w_addr   = w_gnt ? req_addr[DM_ADDRESS +: DM_ADDRESS] : req_addr[0 +: DM_ADDRESS];
  assign w_wdata  = w_gnt ? req_wdata[DATA_W +: DATA_W] : req_wdata[0 +: DATA_W];
  assign w_funct3 = w_gnt ? req_funct3[5:3] : req_funct3[2:0];

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state  <= IDLE;
      r_rrLast <= 1'b1;
      r_gnt    <= 1'b0;
      r_write  <= 1'b0;
      r_addr   <= '0;
      r_wdata  <= '0;
      r_funct3 <= '0;
      r_rdata  <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (|req_valid) begin
            r_gnt    <= w_gnt;
            r_rrLast <= w_gnt;
            r_write  <= w_write;
            r_addr   <= w_addr;
            r_wdata  <= w_wdata;
            r_funct3 <= w_funct3;
            r_state  <= ACCESS;
          end
        end
        ACCESS: begin
          // Stores leave the previous load data visible on rsp_rdata.
          if (!r_write) begin
            r_rdata <= rd;
          end
          r_state <= RESP;
        end
        RESP: begin
          r_state <= IDLE;
        end
        default: begin
          r_state <= IDLE;
        end
      endcase
    end
  end

  assign req_ready = ((r_state == IDLE) && (|req_valid)) ? (w_gnt ? 2'b10 : 2'b01) : 2'b00;
  assign rsp_valid = (r_state == RESP) ? {r_gnt, ~r_gnt} : 2'b00;
  assign rsp_rdata = r_rdata;
  assign busy      = (r_state != IDLE);
  assign MemRead   = (r_state == ACCESS) && !r_write;
  assign MemWrite  = (r_state == ACCESS) && r_write;
  assign a         = r_addr;
  assign wd        = r_wdata;
  assign Funct3    = r_funct3;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Scoreboard bench for dmem_arbiter: a byte-addressed memory model behind the arbiter,
// directed transactions push expected responses, and a monitor checks every rsp pulse.
module tb_dmem_arbiter;
  localparam int AW = 9;
  localparam int DW = 32;

  logic          clk = 1'b0;
  logic          reset;
  logic [1:0]    req_valid;
  logic [1:0]    req_write;
  logic [2*AW-1:0] req_addr;
  logic [2*DW-1:0] req_wdata;
  logic [5:0]    req_funct3;
  logic [1:0]    req_ready;
  logic [1:0]    rsp_valid;
  logic [DW-1:0] rsp_rdata;
  logic          busy;
  logic          MemRead;
  logic          MemWrite;
  logic [AW-1:0] a;
  logic [DW-1:0] wd;
  logic [2:0]    Funct3;
  logic [DW-1:0] rd;

  int totalCount = 0;
  int badCount   = 0;

  always #5 clk = ~clk;

  dmem_arbiter #(.DM_ADDRESS(AW), .DATA_W(DW)) dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_write(req_write), .req_addr(req_addr),
    .req_wdata(req_wdata), .req_funct3(req_funct3), .req_ready(req_ready),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .busy(busy),
    .MemRead(MemRead), .MemWrite(MemWrite), .a(a), .wd(wd), .Funct3(Funct3), .rd(rd)
  );

  // Data memory model: combinational read with RISC-V load extension, byte-enabled writes.
  logic [7:0] mem [0:511];

  always_comb begin
    rd = '0;
    case (Funct3)
      3'b000:  rd = {{24{mem[a][7]}}, mem[a]};
      3'b001:  rd = {{16{mem[a + 9'd1][7]}}, mem[a + 9'd1], mem[a]};
      3'b100:  rd = {24'd0, mem[a]};
      3'b101:  rd = {16'd0, mem[a + 9'd1], mem[a]};
      default: rd = {mem[a + 9'd3], mem[a + 9'd2], mem[a + 9'd1], mem[a]};
    endcase
  end

  always @(posedge clk) begin
    if (MemWrite) begin
      case (Funct3)
        3'b000: mem[a] <= wd[7:0];
        3'b001: begin
          mem[a]         <= wd[7:0];
          mem[a + 9'd1]  <= wd[15:8];
        end
        default: begin
          mem[a]         <= wd[7:0];
          mem[a + 9'd1]  <= wd[15:8];
          mem[a + 9'd2]  <= wd[23:16];
          mem[a + 9'd3]  <= wd[31:24];
        end
      endcase
    end
  end

  typedef struct packed {
    logic [1:0]  port;
    logic [31:0] data;
  } exp_t;

  exp_t        expQ[$];
  logic [31:0] lastLoad = '0;

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    totalCount++;
    if (act !== exp) begin
      badCount++;
      $display("[TB] FAIL %s: got %0h, required %0h", name, act, exp);
    end
  endtask

  // Stores echo the previously loaded data, so the model tracks it as responses are queued.
  task automatic pushExp(input int port, input logic wr, input logic [31:0] data);
    exp_t e;
    e.port = (port == 1) ? 2'b10 : 2'b01;
    if (!wr) lastLoad = data;
    e.data = lastLoad;
    expQ.push_back(e);
  endtask

  always @(negedge clk) begin : monitor
    exp_t e;
    if (rsp_valid !== 2'b00) begin
      if (expQ.size() == 0) begin
        totalCount++;
        badCount++;
        $display("[TB] FAIL rsp_unexpected: got rsp_valid=%b, required none", rsp_valid);
      end else begin
        e = expQ.pop_front();
        checkOutput("rsp_port", {62'd0, rsp_valid}, {62'd0, e.port});
        checkOutput("rsp_rdata", {32'd0, rsp_rdata}, {32'd0, e.data});
      end
    end
  end

  task automatic driveReq(input int port, input logic wr, input logic [AW-1:0] addr,
                          input logic [DW-1:0] wdata, input logic [2:0] f3);
    req_write[port]          = wr;
    req_addr[port*AW +: AW]  = addr;
    req_wdata[port*DW +: DW] = wdata;
    req_funct3[port*3 +: 3]  = f3;
  endtask

  task automatic waitReady(output int waited, output bit ok);
    ok = 1'b0;
    waited = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (req_ready != 2'b00) begin
        ok = 1'b1;
        break;
      end
      waited++;
    end
    if (!ok) begin
      totalCount++;
      badCount++;
      $display("[TB] FAIL ready_timeout: got no req_ready in 20 cycles, required a grant");
    end
  endtask

  task automatic applyStimulus(input int port, input logic wr, input logic [AW-1:0] addr,
                               input logic [DW-1:0] wdata, input logic [2:0] f3,
                               input logic [31:0] expData);
    int waited;
    bit ok;
    pushExp(port, wr, expData);
    @(posedge clk); #1;
    driveReq(port, wr, addr, wdata, f3);
    req_valid[port] = 1'b1;
    waitReady(waited, ok);
    if (ok) begin
      checkOutput("accept_latency", 64'(waited), 64'd0);
      checkOutput("accept_ready", {62'd0, req_ready}, (port == 1) ? 64'd2 : 64'd1);
      checkOutput("idle_strobes", {62'd0, MemRead, MemWrite}, 64'd0);
      @(posedge clk); #1;
      req_valid = 2'b00;
      @(negedge clk);
      checkOutput("access_strobes", {62'd0, MemRead, MemWrite}, {62'd0, !wr, wr});
      checkOutput("access_addr", {55'd0, a}, {55'd0, addr});
      checkOutput("access_wd", {32'd0, wd}, {32'd0, wdata});
      checkOutput("access_funct3", {61'd0, Funct3}, {61'd0, f3});
      checkOutput("access_busy_ready", {61'd0, busy, req_ready}, 64'h4);
      @(negedge clk);
      checkOutput("resp_strobes_busy", {61'd0, MemRead, MemWrite, busy}, 64'd1);
    end else begin
      req_valid = 2'b00;
    end
  endtask

  task automatic resetDut();
    reset = 1'b1;
    req_valid = 2'b00;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    lastLoad = '0;
  endtask

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: got simulation still running, required completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int  waited;
    bit  ok;
    int  grants;
    int  cyc;
    int  lastCyc;

    reset      = 1'b1;
    req_valid  = '0;
    req_write  = '0;
    req_addr   = '0;
    req_wdata  = '0;
    req_funct3 = '0;

    // Reset state, sampled while reset is still asserted.
    @(negedge clk);
    checkOutput("reset_ctrl", {57'd0, req_ready, rsp_valid, busy, MemRead, MemWrite}, 64'd0);
    checkOutput("reset_data", {rsp_rdata, wd}, 64'd0);
    checkOutput("reset_addr_f3", {52'd0, a, Funct3}, 64'd0);
    @(posedge clk); #1;
    reset = 1'b0;

    // Preload word 0x010 through port 1, then start clean.
    applyStimulus(1, 1'b1, 9'h010, 32'hDEADBEEF, 3'b010, 32'h0);
    resetDut();

    // Single port-0 load.
    applyStimulus(0, 1'b0, 9'h010, 32'h0, 3'b010, 32'hDEADBEEF);

    // Port-1 store, then read back.
    applyStimulus(1, 1'b1, 9'h024, 32'h12345678, 3'b010, 32'h0);
    applyStimulus(1, 1'b0, 9'h024, 32'h0, 3'b010, 32'h12345678);

    // Both ports continuously valid from reset: grants alternate, 3 cycles apart.
    resetDut();
    for (int i = 0; i < 6; i++) pushExp(i % 2, 1'b0, (i % 2) ? 32'h12345678 : 32'hDEADBEEF);
    @(posedge clk); #1;
    driveReq(0, 1'b0, 9'h010, 32'h0, 3'b010);
    driveReq(1, 1'b0, 9'h024, 32'h0, 3'b010);
    req_valid = 2'b11;
    grants = 0;
    cyc = 0;
    lastCyc = 0;
    while (grants < 6 && cyc < 40) begin
      @(negedge clk);
      if (req_ready != 2'b00) begin
        checkOutput("rr_grant", {62'd0, req_ready}, (grants % 2) ? 64'd2 : 64'd1);
        if (grants > 0) checkOutput("rr_spacing", 64'(cyc - lastCyc), 64'd3);
        lastCyc = cyc;
        grants++;
      end
      cyc++;
    end
    if (grants < 6) checkOutput("rr_grant_count", 64'(grants), 64'd6);
    @(posedge clk); #1;
    req_valid = 2'b00;
    repeat (3) @(negedge clk);

    // Port 0 waits through ACCESS/RESP; payload at the accept cycle is what gets used.
    pushExp(1, 1'b0, 32'h12345678);
    pushExp(0, 1'b0, 32'hDEADBEEF);
    @(posedge clk); #1;
    driveReq(1, 1'b0, 9'h024, 32'h0, 3'b010);
    req_valid = 2'b10;
    waitReady(waited, ok);
    checkOutput("t4_grant1", {62'd0, req_ready}, 64'd2);
    @(posedge clk); #1;
    driveReq(0, 1'b0, 9'h100, 32'h0, 3'b010);
    req_valid = 2'b01;
    @(negedge clk);
    checkOutput("t4_ready_access", {62'd0, req_ready}, 64'd0);
    checkOutput("t4_hold_addr", {55'd0, a}, 64'h024);
    @(posedge clk); #1;
    driveReq(0, 1'b0, 9'h010, 32'h0, 3'b010);
    @(negedge clk);
    checkOutput("t4_ready_resp", {62'd0, req_ready}, 64'd0);
    @(negedge clk);
    checkOutput("t4_ready_idle", {62'd0, req_ready}, 64'd1);
    @(posedge clk); #1;
    req_valid = 2'b00;
    @(negedge clk);
    checkOutput("t4_late_payload", {55'd0, a}, 64'h010);
    repeat (2) @(negedge clk);

    // Reset during ACCESS of a port-1 load: no response, everything cleared.
    @(posedge clk); #1;
    driveReq(1, 1'b0, 9'h024, 32'h0, 3'b010);
    req_valid = 2'b10;
    waitReady(waited, ok);
    @(posedge clk); #1;
    req_valid = 2'b00;
    @(negedge clk);
    checkOutput("t5_in_access", {63'd0, MemRead}, 64'd1);
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    lastLoad = '0;
    @(negedge clk);
    checkOutput("t5_rst_ctrl", {52'd0, req_ready, rsp_valid, busy, MemRead, MemWrite, Funct3},
                64'd0);
    checkOutput("t5_rst_data", {rsp_rdata, wd}, 64'd0);
    checkOutput("t5_rst_addr", {55'd0, a}, 64'd0);
    pushExp(0, 1'b0, 32'hDEADBEEF);
    @(posedge clk); #1;
    driveReq(0, 1'b0, 9'h010, 32'h0, 3'b010);
    driveReq(1, 1'b0, 9'h024, 32'h0, 3'b010);
    req_valid = 2'b11;
    waitReady(waited, ok);
    checkOutput("t5_conflict_grant", {62'd0, req_ready}, 64'd1);
    @(posedge clk); #1;
    req_valid = 2'b00;
    repeat (2) @(negedge clk);

    // Byte store then sign-extending byte load.
    applyStimulus(0, 1'b1, 9'h013, 32'h00000080, 3'b000, 32'h0);
    applyStimulus(0, 1'b0, 9'h013, 32'h0, 3'b000, 32'hFFFFFF80);

    repeat (3) @(negedge clk);
    checkOutput("queue_empty", 64'(expQ.size()), 64'd0);
    $display("test done: total=%0d bad=%0d", totalCount, badCount);
    $finish;
  end

endmodule
